// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one 16-bit single-port memory between
// instruction fetch and data load/store; 32-bit data accesses become two beats.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic                    d_wide,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [2*DATA_WIDTH-1:0] d_wdata,
  output logic                    d_gnt,
  output logic                    d_done,
  output logic [2*DATA_WIDTH-1:0] d_rdata,
  output logic                    mem_en,
  output logic                    mem_rd_en,
  output logic                    mem_wr_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  typedef enum logic {ST_ISSUE, ST_HI} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;
  typedef enum logic [1:0] {BEAT_NARROW, BEAT_LO, BEAT_HI} beat_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
    beat_t  beat;
    logic   rd;
  } tag_t;

  state_t                  state;
  owner_t                  last;
  tag_t                    tag;
  logic [ADDR_WIDTH-1:0]   hi_addr;
  logic [DATA_WIDTH-1:0]   hi_wdata;
  logic                    hi_we;
  logic [DATA_WIDTH-1:0]   lo_reg;
  logic                    pick_if;
  logic                    pick_d;

  // Arbitration: the requester not granted last wins a contention.
  always_comb begin
    pick_if = 1'b0;
    pick_d  = 1'b0;
    if (!reset && state == ST_ISSUE) begin
      pick_if = if_req && (!d_req || last == OWN_D);
      pick_d  = d_req && !pick_if;
    end
  end

  // Memory port drive: first beat straight from the winner, second beat from latches.
  always_comb begin
    if_gnt    = pick_if;
    d_gnt     = pick_d;
    mem_en    = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (pick_if) begin
      mem_en    = 1'b1;
      mem_rd_en = 1'b1;
      mem_addr  = if_addr;
    end else if (pick_d) begin
      mem_en    = 1'b1;
      mem_rd_en = !d_we;
      mem_wr_en = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_we ? d_wdata[DATA_WIDTH-1:0] : '0;
    end else if (!reset && state == ST_HI) begin
      mem_en    = 1'b1;
      mem_rd_en = !hi_we;
      mem_wr_en = hi_we;
      mem_addr  = hi_addr;
      mem_wdata = hi_we ? hi_wdata : '0;
    end
  end

  // Response steering from the tag of the beat issued last cycle.
  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_done    = 1'b0;
    d_rdata   = '0;
    if (!reset && tag.valid) begin
      if (tag.owner == OWN_IF) begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
      end else if (tag.beat != BEAT_LO) begin
        d_done = 1'b1;
        if (tag.rd) begin
          d_rdata = (tag.beat == BEAT_HI) ? {mem_rdata, lo_reg}
                                          : {{DATA_WIDTH{1'b0}}, mem_rdata};
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_ISSUE;
      last     <= OWN_D;
      tag      <= '0;
      hi_addr  <= '0;
      hi_wdata <= '0;
      hi_we    <= 1'b0;
      lo_reg   <= '0;
    end else begin
      tag <= '0;
      if (tag.valid && tag.owner == OWN_D && tag.beat == BEAT_LO && tag.rd) begin
        lo_reg <= mem_rdata;
      end
      if (state == ST_HI) begin
        tag   <= tag_t'{valid: 1'b1, owner: OWN_D, beat: BEAT_HI, rd: !hi_we};
        state <= ST_ISSUE;
      end else if (pick_if) begin
        tag  <= tag_t'{valid: 1'b1, owner: OWN_IF, beat: BEAT_NARROW, rd: 1'b1};
        last <= OWN_IF;
      end else if (pick_d) begin
        tag  <= tag_t'{valid: 1'b1, owner: OWN_D,
                       beat: (d_wide ? BEAT_LO : BEAT_NARROW), rd: !d_we};
        last <= OWN_D;
        if (d_wide) begin
          // High beat address wraps modulo the memory depth.
          state    <= ST_HI;
          hi_addr  <= d_addr + ADDR_WIDTH'(1);
          hi_wdata <= d_wdata[2*DATA_WIDTH-1:DATA_WIDTH];
          hi_we    <= d_we;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle vectors for grant/port drive, a reference
// memory with response scoreboard, and hand sequences for wide and reset cases.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [11:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [15:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0, d_wide = 1'b0;
  logic [11:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt, d_done;
  logic [31:0] d_rdata;
  logic        mem_en, mem_rd_en, mem_wr_en;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_wide(d_wide), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [15:0] init_val(int unsigned a);
    return (a == 16) ? 16'hA5A5 : (16'(a) ^ 16'hC300);
  endfunction

  // Memory behaviour: one-cycle read latency, preloaded on the first edge.
  logic [15:0] ram [0:4095];
  bit          mem_loaded = 1'b0;
  always @(posedge clock) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 4096; i++) ram[i] <= init_val(i);
      mem_loaded <= 1'b1;
    end else begin
      if (mem_en && mem_wr_en) ram[mem_addr] <= mem_wdata;
      if (mem_en && mem_rd_en) mem_rdata <= ram[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  function automatic logic [32:0] outv();
    return {if_gnt, d_gnt, mem_en, mem_rd_en, mem_wr_en, mem_addr, mem_wdata};
  endfunction

  function automatic logic [95:0] allout();
    return 96'({if_gnt, if_rvalid, if_rdata, d_gnt, d_done, d_rdata,
                mem_en, mem_rd_en, mem_wr_en, mem_addr, mem_wdata});
  endfunction

  // Scoreboard: expectations pushed at grant, popped at the response pulse.
  typedef struct {
    logic [31:0] data;
    int          due;
    logic        hi_wr;
    logic [11:0] hi_addr;
    logic [15:0] hi_data;
  } exp_t;

  exp_t        if_q[$];
  exp_t        d_q[$];
  exp_t        mon_e;
  logic [15:0] ref_mem [0:4095];
  bit          ref_loaded = 1'b0;
  logic [11:0] mon_a1;

  always @(negedge clock) begin
    if (!ref_loaded) begin
      for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
      ref_loaded = 1'b1;
    end
    if (reset) begin
      if_q.delete();
      d_q.delete();
    end else begin
      while (if_q.size() > 0 && if_q[0].due < cyc) begin
        fail_now("if_rvalid_missing");
        void'(if_q.pop_front());
      end
      while (d_q.size() > 0 && d_q[0].due < cyc) begin
        fail_now("d_done_missing");
        void'(d_q.pop_front());
      end
      if (if_rvalid) begin
        if (if_q.size() > 0 && if_q[0].due == cyc) begin
          mon_e = if_q.pop_front();
          chk("if_rdata", 96'(if_rdata), 96'(mon_e.data));
        end else fail_now("if_rvalid_unexpected");
      end else chk("if_rdata_idle", 96'(if_rdata), 96'(0));
      if (d_done) begin
        if (d_q.size() > 0 && d_q[0].due == cyc) begin
          mon_e = d_q.pop_front();
          chk("d_rdata", 96'(d_rdata), 96'(mon_e.data));
          if (mon_e.hi_wr) ref_mem[mon_e.hi_addr] = mon_e.hi_data;
        end else fail_now("d_done_unexpected");
      end else chk("d_rdata_idle", 96'(d_rdata), 96'(0));
      chk("rd_wr_exclusive", 96'(mem_rd_en && mem_wr_en), 96'(0));
      if (if_gnt) begin
        mon_e = '{data: {16'h0, ref_mem[if_addr]}, due: cyc + 1,
                  hi_wr: 1'b0, hi_addr: '0, hi_data: '0};
        if_q.push_back(mon_e);
      end
      if (d_gnt) begin
        mon_a1 = d_addr + 12'd1;
        mon_e = '{data: '0, due: cyc + (d_wide ? 2 : 1),
                  hi_wr: 1'b0, hi_addr: '0, hi_data: '0};
        if (d_we) begin
          ref_mem[d_addr] = d_wdata[15:0];
          if (d_wide) begin
            mon_e.hi_wr   = 1'b1;
            mon_e.hi_addr = mon_a1;
            mon_e.hi_data = d_wdata[31:16];
          end
        end else begin
          mon_e.data = d_wide ? {ref_mem[mon_a1], ref_mem[d_addr]}
                              : {16'h0, ref_mem[d_addr]};
        end
        d_q.push_back(mon_e);
      end
    end
  end

  typedef struct packed {
    logic        ir;
    logic [11:0] ia;
    logic        dr;
    logic        dwe;
    logic        dwide;
    logic [11:0] da;
    logic [31:0] dwd;
    logic [32:0] exp;
  } vec_t;

  function automatic vec_t mk(logic ir, logic [11:0] ia, logic dr, logic dwe,
                              logic [11:0] da, logic [31:0] dwd, logic [32:0] e);
    vec_t v;
    v = '{ir: ir, ia: ia, dr: dr, dwe: dwe, dwide: 1'b0, da: da, dwd: dwd, exp: e};
    return v;
  endfunction

  task automatic idle_inputs();
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wide = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  vec_t vecs[13];

  initial begin
    // exp = {if_gnt, d_gnt, en, rd_en, wr_en, addr, wdata}
    vecs[0]  = mk(1, 12'h100, 1, 0, 12'h200, 0, {2'b10, 3'b110, 12'h100, 16'h0});
    vecs[1]  = mk(1, 12'h101, 1, 0, 12'h200, 0, {2'b01, 3'b110, 12'h200, 16'h0});
    vecs[2]  = mk(1, 12'h101, 1, 0, 12'h201, 0, {2'b10, 3'b110, 12'h101, 16'h0});
    vecs[3]  = mk(1, 12'h102, 1, 0, 12'h201, 0, {2'b01, 3'b110, 12'h201, 16'h0});
    vecs[4]  = mk(1, 12'h102, 1, 0, 12'h202, 0, {2'b10, 3'b110, 12'h102, 16'h0});
    vecs[5]  = mk(1, 12'h103, 1, 0, 12'h202, 0, {2'b01, 3'b110, 12'h202, 16'h0});
    vecs[6]  = mk(1, 12'h103, 0, 0, 12'h000, 0, {2'b10, 3'b110, 12'h103, 16'h0});
    vecs[7]  = mk(0, 12'h000, 1, 1, 12'h300, 32'h0000BEEF, {2'b01, 3'b101, 12'h300, 16'hBEEF});
    vecs[8]  = mk(0, 12'h000, 0, 0, 12'h000, 0, 33'h0);
    vecs[9]  = mk(1, 12'h010, 0, 0, 12'h000, 0, {2'b10, 3'b110, 12'h010, 16'h0});
    vecs[10] = mk(0, 12'h000, 1, 0, 12'h300, 0, {2'b01, 3'b110, 12'h300, 16'h0});
    vecs[11] = mk(1, 12'h011, 1, 1, 12'h301, 32'h00001111, {2'b10, 3'b110, 12'h011, 16'h0});
    vecs[12] = mk(0, 12'h000, 1, 1, 12'h301, 32'h00001111, {2'b01, 3'b101, 12'h301, 16'h1111});

    // Reset held with both requesting: nothing may leave the block.
    reset = 1'b1; if_req = 1'b1; d_req = 1'b1; if_addr = 12'h100; d_addr = 12'h200;
    repeat (3) begin
      @(negedge clock);
      chk("reset_outputs", allout(), 96'(0));
    end
    next_cycle();
    reset = 1'b0;

    // Cycle vectors: contention alternation, narrow write/read, fetch of 0x010.
    for (int i = 0; i < 13; i++) begin
      if_req = vecs[i].ir; if_addr = vecs[i].ia;
      d_req = vecs[i].dr; d_we = vecs[i].dwe; d_wide = vecs[i].dwide;
      d_addr = vecs[i].da; d_wdata = vecs[i].dwd;
      @(negedge clock);
      chk($sformatf("vec%0d", i), 96'(outv()), 96'(vecs[i].exp));
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // Wide write at the top of memory: high beat wraps to 0x000.
    d_req = 1'b1; d_we = 1'b1; d_wide = 1'b1; d_addr = 12'hFFF; d_wdata = 32'h12345678;
    @(negedge clock);
    chk("wwr_lo", 96'(outv()), 96'({2'b01, 3'b101, 12'hFFF, 16'h5678}));
    next_cycle();
    idle_inputs();
    @(negedge clock);
    chk("wwr_hi", 96'(outv()), 96'({2'b00, 3'b101, 12'h000, 16'h1234}));
    next_cycle();
    @(negedge clock);
    chk("wwr_done", 96'({d_done, d_rdata}), 96'({1'b1, 32'h0}));
    chk("ram_fff", 96'(ram[12'hFFF]), 96'(16'h5678));
    chk("ram_000", 96'(ram[12'h000]), 96'(16'h1234));
    next_cycle();

    // Fetch alone so IF was last, then wide read contending with a fetch.
    if_req = 1'b1; if_addr = 12'h005;
    @(negedge clock);
    chk("fetch_gnt", 96'(outv()), 96'({2'b10, 3'b110, 12'h005, 16'h0}));
    next_cycle();
    if_addr = 12'h010;
    d_req = 1'b1; d_we = 1'b0; d_wide = 1'b1; d_addr = 12'hFFF;
    @(negedge clock);
    chk("wrd_lo", 96'(outv()), 96'({2'b01, 3'b110, 12'hFFF, 16'h0}));
    next_cycle();
    d_req = 1'b0; d_wide = 1'b0;
    @(negedge clock);
    chk("wrd_hi", 96'(outv()), 96'({2'b00, 3'b110, 12'h000, 16'h0}));
    next_cycle();
    @(negedge clock);
    chk("wrd_if_deferred", 96'(outv()), 96'({2'b10, 3'b110, 12'h010, 16'h0}));
    chk("wrd_data", 96'({d_done, d_rdata}), 96'({1'b1, 32'h12345678}));
    next_cycle();
    idle_inputs();
    next_cycle();

    // Reset lands while the high beat of a wide write is pending.
    d_req = 1'b1; d_we = 1'b1; d_wide = 1'b1; d_addr = 12'h020; d_wdata = 32'hCAFEF00D;
    @(negedge clock);
    chk("rst_wide_gnt", 96'(outv()), 96'({2'b01, 3'b101, 12'h020, 16'hF00D}));
    next_cycle();
    idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_outputs", allout(), 96'(0));
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_no_done", 96'(d_done), 96'(0));
    chk("ram_021_kept", 96'(ram[12'h021]), 96'(init_val(12'h021)));
    chk("ram_020_lo", 96'(ram[12'h020]), 96'(16'hF00D));
    next_cycle();
    d_req = 1'b1; d_we = 1'b0; d_wide = 1'b0; d_addr = 12'h021;
    @(negedge clock);
    chk("post_rst_gnt", 96'(outv()), 96'({2'b01, 3'b110, 12'h021, 16'h0}));
    next_cycle();
    idle_inputs();
    @(negedge clock);
    chk("post_rst_done", 96'({d_done, d_rdata}), 96'({1'b1, 16'h0, 16'hC321}));

    repeat (4) next_cycle();
    @(negedge clock);
    chk("scoreboard_drained", 96'(if_q.size() + d_q.size()), 96'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
